// File: rtl/bytecode_fetch_if.sv
// bytecode_fetch_if: bundles the control, ROM and decoder-side signals of the
// bytecode fetch stage.
//   slave  - the fetch stage itself (takes start/jump/ROM data/ready, drives
//            ROM address, head byte/pc/valid and status).
//   master - the environment around it (sequencer, ROM, decoder).
interface bytecode_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [ADDR_W-1:0] rom_size;
    logic [7:0]        out_byte;
    logic [ADDR_W-1:0] out_pc;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  start, start_addr, jump, jump_addr, rom_data, rom_size, out_ready,
        output rom_addr, out_byte, out_pc, out_valid, busy, done
    );

    modport master (
        output start, start_addr, jump, jump_addr, rom_data, rom_size, out_ready,
        input  rom_addr, out_byte, out_pc, out_valid, busy, done
    );
endinterface

// File: rtl/bytecode_fetch.sv
// bytecode_fetch: sequential fetch stage behind the bytecode ROM. Walks a fetch
// pointer across the image, captures each byte with its address into a small
// prefetch FIFO and streams the head to the decoder over valid/ready.
// Ports:
//   clk    - single rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - bytecode_fetch_if.slave: start/start_addr, jump/jump_addr,
//            rom_addr/rom_data/rom_size, out_byte/out_pc/out_valid/out_ready,
//            busy/done
module bytecode_fetch #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    bytecode_fetch_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fptr_q, fptr_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0]        mem_byte_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];

    logic              active;
    logic              jump_take;
    logic              start_take;
    logic              pop;
    logic              push;
    logic              out_valid;

    assign active     = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign jump_take  = bus.jump && active;
    assign start_take = bus.start && !active;
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && bus.out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts a
    // push and throughput stays at one byte per cycle. Pushes in a jump cycle
    // are discarded because the FIFO is being flushed.
    assign push       = (state_q == S_FETCH) && (fptr_q < bus.rom_size) &&
                        ((count_q != CNT_W'(DEPTH)) || pop) && !jump_take;

    always_comb begin
        state_d = state_q;
        fptr_d  = fptr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (jump_take || start_take) begin
            state_d = S_FETCH;
            fptr_d  = jump_take ? bus.jump_addr : bus.start_addr;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
                fptr_d = fptr_q + ADDR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // End-of-image is judged on the current pointer, so a start or jump
            // beyond the image spends one cycle in FETCH before DRAIN.
            case (state_q)
                S_FETCH: if (fptr_q >= bus.rom_size) state_d = S_DRAIN;
                S_DRAIN: if (count_q == '0)          state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
        busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fptr_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fptr_q  <= fptr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // FIFO storage carries no reset; the outputs are gated by valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_byte_q[tail_q] <= bus.rom_data;
            mem_pc_q[tail_q]   <= fptr_q;
        end
    end

    assign bus.rom_addr  = fptr_q;
    assign bus.out_valid = out_valid;
    // Gating keeps byte/pc at 0 whenever nothing is valid, including right
    // after reset when the storage is uninitialised.
    assign bus.out_byte  = out_valid ? mem_byte_q[head_q] : '0;
    assign bus.out_pc    = out_valid ? mem_pc_q[head_q]   : '0;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bytecode_fetch.sv
module tb_bytecode_fetch;
    logic clk;
    logic rst_n;

    bytecode_fetch_if #(.ADDR_W(16)) bus();

    bytecode_fetch #(.ADDR_W(16), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] rom [256];
    assign bus.rom_data = rom[bus.rom_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the decoder must see the image as a plain sequence of
    // addresses exp_pc, exp_pc+1, ... up to rom_size-1, restarted by start or
    // jump. phase: 0 idle, 1 running, 2 done.
    int cyc;
    int exp_pc;
    int phase;
    int due;
    int fill_at;
    int beats;
    int first_beat_edge;
    int last_beat_edge;
    int rom_sz;
    int ready_pct;
    int jumps_left;
    bit rand_start;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        logic hs;
        logic hold;
        logic ev;
        int   edge_n;
        int   addr;
        edge_n = cyc + 1;
        ev     = 1'b0;
        hs     = bus.out_valid && bus.out_ready;
        hold   = bus.out_valid && !bus.out_ready;
        if (hs) begin
            check_val("beat_pc", 32'(bus.out_pc), 32'(exp_pc));
            check_val("beat_byte", 32'(bus.out_byte), 32'(rom[exp_pc[7:0]]));
            if (first_beat_edge < 0) first_beat_edge = edge_n;
            last_beat_edge = edge_n;
            beats++;
            exp_pc++;
            if (exp_pc == rom_sz) due = edge_n + 1;
        end
        if (bus.jump && phase == 1) begin
            addr   = int'(bus.jump_addr);
            exp_pc = addr;
            due    = (addr >= rom_sz) ? edge_n + 2 : 0;
            ev     = 1'b1;
            hold   = 1'b0;
        end else if (bus.start && phase != 1) begin
            addr   = int'(bus.start_addr);
            exp_pc = addr;
            phase  = 1;
            due    = (addr >= rom_sz) ? edge_n + 2 : 0;
            ev     = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.start = 1'b0;
        bus.jump  = 1'b0;
        if (phase == 1 && due != 0 && cyc == due) phase = 2;
        check_val("busy", 32'(bus.busy), 32'(phase == 1));
        check_val("done", 32'(bus.done), 32'(phase == 2));
        if (ev) begin
            check_val("redirect_valid", 32'(bus.out_valid), 32'd0);
            check_val("redirect_rom_addr", 32'(bus.rom_addr), 32'(exp_pc));
            fill_at = cyc + 1;
        end else if (cyc == fill_at) begin
            check_val("fill_valid", 32'(bus.out_valid), 32'(exp_pc < rom_sz));
            fill_at = -1;
        end
        if (hold) check_val("hold_valid", 32'(bus.out_valid), 32'd1);
        if (phase != 1) check_val("idle_valid", 32'(bus.out_valid), 32'd0);
        if (bus.out_valid) begin
            check_val("head_pc", 32'(bus.out_pc), 32'(exp_pc));
            check_val("head_byte", 32'(bus.out_byte), 32'(rom[exp_pc[7:0]]));
            check_val("head_in_image", 32'(exp_pc < rom_sz), 32'd1);
        end
    endtask

    task automatic run_to_done(input int bound);
        int n;
        n = 0;
        while (phase != 2 && n < bound) begin
            if (ready_pct > 0) bus.out_ready = ($urandom_range(99) < ready_pct);
            if (jumps_left > 0 && $urandom_range(99) < 4) begin
                bus.jump      = 1'b1;
                bus.jump_addr = 16'($urandom_range(0, rom_sz + 3));
                jumps_left--;
            end
            if (rand_start && $urandom_range(99) < 3) begin
                bus.start      = 1'b1;
                bus.start_addr = 16'($urandom_range(0, rom_sz));
            end
            tick();
            n++;
        end
        check_val("reach_done", 32'(phase), 32'd2);
    endtask

    task automatic pulse_start(input int addr);
        bus.start      = 1'b1;
        bus.start_addr = 16'(addr);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        check_val({tag, "_out_byte"}, 32'(bus.out_byte), 32'd0);
        check_val({tag, "_out_pc"}, 32'(bus.out_pc), 32'd0);
        check_val({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_val({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int s_edge;
        int b0;
        int n;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i * 37 + 11);
        for (int i = 0; i < 6; i++) rom[i] = 8'h66;
        rom[6]  = 8'h00;
        rom[7]  = 8'h12;
        rom[29] = 8'h3b;
        rom[30] = 8'h3c;
        rom[31] = 8'h3d;
        rom[32] = 8'h3e;
        rom[46] = 8'h5f;
        rom[47] = 8'h15;
        rom[48] = 8'h00;

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.jump       = 1'b0;
        bus.jump_addr  = '0;
        bus.out_ready  = 1'b0;
        rom_sz         = 49;
        bus.rom_size   = 16'(rom_sz);
        cyc = 0; exp_pc = 0; phase = 0; due = 0; fill_at = -1; beats = 0;
        first_beat_edge = -1; last_beat_edge = -1;
        ready_pct = 0; jumps_left = 0; rand_start = 1'b0;

        @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        // Full image at full rate
        bus.out_ready = 1'b1;
        first_beat_edge = -1;
        b0 = beats;
        s_edge = cyc + 1;
        pulse_start(0);
        run_to_done(100);
        check_val("full_cycles", 32'(cyc - s_edge), 32'd51);
        check_val("full_beats", 32'(beats - b0), 32'd49);
        check_val("full_gapless", 32'(last_beat_edge - first_beat_edge), 32'd48);
        check_val("full_done_lat", 32'(cyc - last_beat_edge), 32'd1);

        // Back-pressure
        bus.out_ready = 1'b0;
        pulse_start(0);
        repeat (10) tick();
        check_val("bp_rom_addr", 32'(bus.rom_addr), 32'd4);
        check_val("bp_valid", 32'(bus.out_valid), 32'd1);
        check_val("bp_pc", 32'(bus.out_pc), 32'd0);
        check_val("bp_byte", 32'(bus.out_byte), 32'h66);
        bus.out_ready = 1'b1;
        b0 = beats;
        repeat (8) tick();
        check_val("bp_release_beats", 32'(beats - b0), 32'd8);
        run_to_done(100);

        // Jump after the pc-5 beat
        bus.out_ready = 1'b1;
        pulse_start(0);
        n = 0;
        while (exp_pc < 6 && n < 50) begin
            tick();
            n++;
        end
        check_val("jump_pre_pc", 32'(exp_pc), 32'd6);
        bus.out_ready = 1'b0;
        bus.jump      = 1'b1;
        bus.jump_addr = 16'd29;
        tick();
        check_val("jump_rom_addr", 32'(bus.rom_addr), 32'd29);
        check_val("jump_valid0", 32'(bus.out_valid), 32'd0);
        tick();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_val("jump_seq_valid", 32'(bus.out_valid), 32'd1);
            check_val("jump_seq_pc", 32'(bus.out_pc), 32'(29 + k));
            check_val("jump_seq_byte", 32'(bus.out_byte), 32'(8'h3b + k));
            tick();
        end
        run_to_done(100);

        // Jump past the end of the image
        bus.out_ready = 1'b1;
        pulse_start(0);
        repeat (4) tick();
        bus.jump      = 1'b1;
        bus.jump_addr = 16'd60;
        tick();
        check_val("jpe_valid", 32'(bus.out_valid), 32'd0);
        check_val("jpe_done0", 32'(bus.done), 32'd0);
        tick();
        check_val("jpe_done1", 32'(bus.done), 32'd0);
        tick();
        check_val("jpe_done2", 32'(bus.done), 32'd1);
        run_to_done(5);

        // Start near the end; a second start while busy is ignored
        bus.out_ready = 1'b1;
        b0 = beats;
        pulse_start(47);
        bus.start      = 1'b1;
        bus.start_addr = 16'd3;
        tick();
        run_to_done(50);
        check_val("near_end_beats", 32'(beats - b0), 32'd2);

        // Reset in the middle of a run with three bytes buffered
        bus.out_ready = 1'b0;
        pulse_start(0);
        repeat (3) tick();
        check_val("mid_rst_buffered", 32'(bus.out_valid), 32'd1);
        check_val("mid_rst_rom_addr_pre", 32'(bus.rom_addr), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        phase = 0; due = 0; fill_at = -1; exp_pc = 0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        pulse_start(0);
        tick();
        check_val("post_rst_pc", 32'(bus.out_pc), 32'd0);
        run_to_done(100);

        // Randomised runs with varying image size, ready, jumps and stray starts
        for (int it = 0; it < 12; it++) begin
            rom_sz       = $urandom_range(1, 60);
            bus.rom_size = 16'(rom_sz);
            ready_pct    = 60;
            jumps_left   = 3;
            rand_start   = 1'b1;
            bus.out_ready = 1'b0;
            pulse_start($urandom_range(0, rom_sz + 2));
            run_to_done(600);
            ready_pct  = 0;
            jumps_left = 0;
            rand_start = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
